mem_responder: RTL

Single-port backing-memory responder: the memory-side end of the cache↔memory request protocol. It accepts one read or write request at a time from a cache-side initiator on `rw`/`addr`/`data`, waits a fixed latency, and then completes the transaction with a one-cycle `rdEn` or `wbDone` pulse. It serves as the per-port memory model behind `memBus` and as a standalone responder for cache unit benches.

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_responder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared cache<->memory protocol definitions: field widths and request codes.
package mem_responder_pkg;

    localparam int unsigned IOSTATEWIDTH = 2;
    localparam int unsigned ADDRWIDTH    = 16;
    localparam int unsigned WORDWIDTH    = 16;

    localparam logic [IOSTATEWIDTH-1:0] IO_IDLE  = IOSTATEWIDTH'(0);
    localparam logic [IOSTATEWIDTH-1:0] IO_READ  = IOSTATEWIDTH'(1);
    localparam logic [IOSTATEWIDTH-1:0] IO_WRITE = IOSTATEWIDTH'(2);

    function automatic logic is_request(input logic [IOSTATEWIDTH-1:0] rw);
        return (rw == IO_READ) || (rw == IO_WRITE);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Backing storage: synchronous write, combinational read at the same index.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [WORDWIDTH-1:0] wdata,
    output logic [WORDWIDTH-1:0] rdata
);

    logic [WORDWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then
// completes it with a one-cycle rdEn/wbDone pulse.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned IDX_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IOSTATEWIDTH-1:0] rwFromCache,
    input  logic [ADDRWIDTH-1:0]    addrFromCache,
    input  logic [WORDWIDTH-1:0]    dataFromCache,
    output logic [WORDWIDTH-1:0]    dataToCache,
    output logic                    rdEnToCache,
    output logic                    wbDoneToCache,
    output logic                    errToCache
);

    localparam int unsigned ST_W  = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY    = 2'd1;
    localparam logic [ST_W-1:0] ST_RESP    = 2'd2;
    localparam logic [ST_W-1:0] ST_RELEASE = 2'd3;

    logic [ST_W-1:0]      state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_write_q, op_write_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WORDWIDTH-1:0] wdata_q, wdata_d;
    logic [WORDWIDTH-1:0] data_q, data_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wb_done_q, wb_done_d;
    logic                 err_q, err_d;
    logic                 mem_we_c;
    logic [WORDWIDTH-1:0] mem_rdata_c;
    logic                 unused_addr_hi;

    // Upper address bits are deliberately ignored (index wraps).
    assign unused_addr_hi = ^addrFromCache[ADDRWIDTH-1:IDX_W];

    mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_c & ~reset),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        rd_en_d    = 1'b0;
        wb_done_d  = 1'b0;
        err_d      = err_q;
        mem_we_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_request(rwFromCache)) begin
                    op_write_d = (rwFromCache == IO_WRITE);
                    idx_d      = addrFromCache[IDX_W-1:0];
                    wdata_d    = dataFromCache;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end else if (rwFromCache != IO_IDLE) begin
                    err_d = 1'b1;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Commit/read happens on the edge leaving RESP, so the pulse
                // and read data become visible together.
                if (op_write_q) begin
                    mem_we_c  = 1'b1;
                    wb_done_d = 1'b1;
                end else begin
                    data_d  = mem_rdata_c;
                    rd_en_d = 1'b1;
                end
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (rwFromCache == IO_IDLE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            rd_en_q    <= 1'b0;
            wb_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            rd_en_q    <= rd_en_d;
            wb_done_q  <= wb_done_d;
            err_q      <= err_d;
        end
    end

    assign dataToCache   = data_q;
    assign rdEnToCache   = rd_en_q;
    assign wbDoneToCache = wb_done_q;
    assign errToCache    = err_q;

endmodule
